// File: rtl/stack_vm_sequencer.sv
// stack_vm_sequencer: executes the code generator's stack-machine instruction
// stream. It keeps an operand stack, a local-variable file, a single-cycle ALU
// and an iterative signed divider, and returns the RET value over a
// valid/ready handshake.
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   in_valid/in_ready instruction handshake; in_op opcode, in_arg immediate/slot
//   res_valid/res_ready/res_data  RET value handshake
//   sp                current stack occupancy (0..STACK_DEPTH)
//   err, err_code     sticky error flag and cause (1 ovf, 2 unf, 3 illegal)
module stack_vm_sequencer #(
  parameter int WIDTH       = 32,
  parameter int STACK_DEPTH = 16,
  parameter int NUM_LVARS   = 8
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [3:0]                   in_op,
  input  logic [WIDTH-1:0]             in_arg,
  output logic                         res_valid,
  input  logic                         res_ready,
  output logic [WIDTH-1:0]             res_data,
  output logic [$clog2(STACK_DEPTH):0] sp,
  output logic                         err,
  output logic [1:0]                   err_code
);
  localparam int AW  = $clog2(STACK_DEPTH);
  localparam int SPW = AW + 1;
  localparam int LW  = (NUM_LVARS > 1) ? $clog2(NUM_LVARS) : 1;
  localparam int CW  = $clog2(WIDTH) + 1;

  localparam logic [3:0] OP_PUSH = 4'd0,  OP_LOAD = 4'd1, OP_STORE = 4'd2,
                         OP_ADD  = 4'd3,  OP_SUB  = 4'd4, OP_MUL   = 4'd5,
                         OP_DIV  = 4'd6,  OP_EQ   = 4'd7, OP_NE    = 4'd8,
                         OP_GT   = 4'd9,  OP_GE   = 4'd10, OP_POP  = 4'd11,
                         OP_RET  = 4'd12;
  localparam logic [1:0] E_OVF = 2'd1, E_UNF = 2'd2, E_ILL = 2'd3;

  typedef enum logic [1:0] {S_RUN, S_DIVIDE, S_RESULT, S_ERROR} state_e;

  state_e            state_q, state_d;
  logic [SPW-1:0]    sp_q, sp_d;
  logic [WIDTH-1:0]  stack_q [STACK_DEPTH];
  logic [WIDTH-1:0]  stack_d [STACK_DEPTH];
  logic [WIDTH-1:0]  lvar_q  [NUM_LVARS];
  logic [WIDTH-1:0]  lvar_d  [NUM_LVARS];
  logic [WIDTH-1:0]  res_data_q, res_data_d;
  logic              err_q, err_d;
  logic [1:0]        err_code_q, err_code_d;
  // divider: rem = partial remainder, quo shifts dividend out / quotient in
  logic [WIDTH-1:0]  div_rem_q, div_rem_d, div_quo_q, div_quo_d, div_den_q, div_den_d;
  logic              div_neg_q, div_neg_d;
  logic [CW-1:0]     div_cnt_q, div_cnt_d;

  logic [AW-1:0]     t_idx, n_idx;
  logic [WIDTH-1:0]  t_val, n_val, alu_res, rem_nx, quo_nx;
  logic [WIDTH:0]    rem_sh;
  logic              q_bit, slot_bad, op_bad, op_push, op_slot, accept;
  logic [LW-1:0]     slot;
  logic [1:0]        need;

  assign t_idx    = AW'(sp_q - SPW'(1));
  assign n_idx    = AW'(sp_q - SPW'(2));
  assign t_val    = stack_q[t_idx];
  assign n_val    = stack_q[n_idx];
  assign slot     = in_arg[LW-1:0];
  // the whole argument is range-checked, not just the index bits
  assign slot_bad = (in_arg >= WIDTH'(NUM_LVARS));

  assign in_ready  = (state_q == S_RUN) && !rst;
  assign accept    = in_valid && in_ready;
  assign res_valid = (state_q == S_RESULT);
  assign res_data  = res_data_q;
  assign sp        = sp_q;
  assign err       = err_q;
  assign err_code  = err_code_q;

  // Operand requirements per opcode
  always_comb begin
    op_bad  = 1'b0;
    op_push = 1'b0;
    op_slot = 1'b0;
    need    = 2'd2;
    case (in_op)
      OP_PUSH:  begin need = 2'd0; op_push = 1'b1; end
      OP_LOAD:  begin need = 2'd0; op_push = 1'b1; op_slot = 1'b1; end
      OP_STORE: begin need = 2'd1; op_slot = 1'b1; end
      OP_POP, OP_RET: need = 2'd1;
      OP_ADD, OP_SUB, OP_MUL, OP_DIV, OP_EQ, OP_NE, OP_GT, OP_GE: need = 2'd2;
      default:  op_bad = 1'b1;
    endcase
  end

  always_comb begin
    alu_res = '0;
    case (in_op)
      OP_ADD:  alu_res = n_val + t_val;
      OP_SUB:  alu_res = n_val - t_val;
      OP_MUL:  alu_res = n_val * t_val;
      OP_EQ:   alu_res = WIDTH'(n_val == t_val);
      OP_NE:   alu_res = WIDTH'(n_val != t_val);
      OP_GT:   alu_res = WIDTH'($signed(n_val) >  $signed(t_val));
      OP_GE:   alu_res = WIDTH'($signed(n_val) >= $signed(t_val));
      default: alu_res = '0;
    endcase
  end

  // One restoring step on unsigned magnitudes; rem < den so rem_nx fits WIDTH
  always_comb begin
    rem_sh = {div_rem_q, div_quo_q[WIDTH-1]};
    q_bit  = (rem_sh >= {1'b0, div_den_q});
    rem_nx = q_bit ? WIDTH'(rem_sh - {1'b0, div_den_q}) : rem_sh[WIDTH-1:0];
    quo_nx = {div_quo_q[WIDTH-2:0], q_bit};
  end

  always_comb begin
    state_d    = state_q;
    sp_d       = sp_q;
    stack_d    = stack_q;
    lvar_d     = lvar_q;
    res_data_d = res_data_q;
    err_d      = err_q;
    err_code_d = err_code_q;
    div_rem_d  = div_rem_q;
    div_quo_d  = div_quo_q;
    div_den_d  = div_den_q;
    div_neg_d  = div_neg_q;
    div_cnt_d  = div_cnt_q;
    case (state_q)
      S_RUN: if (accept) begin
        // error priority: opcode, underflow, overflow, slot / zero divisor
        if (op_bad) begin
          state_d = S_ERROR; err_d = 1'b1; err_code_d = E_ILL;
        end else if (sp_q < SPW'(need)) begin
          state_d = S_ERROR; err_d = 1'b1; err_code_d = E_UNF;
        end else if (op_push && sp_q == SPW'(STACK_DEPTH)) begin
          state_d = S_ERROR; err_d = 1'b1; err_code_d = E_OVF;
        end else if ((op_slot && slot_bad) || (in_op == OP_DIV && t_val == '0)) begin
          state_d = S_ERROR; err_d = 1'b1; err_code_d = E_ILL;
        end else begin
          case (in_op)
            OP_PUSH: begin stack_d[sp_q[AW-1:0]] = in_arg;       sp_d = sp_q + SPW'(1); end
            OP_LOAD: begin stack_d[sp_q[AW-1:0]] = lvar_q[slot]; sp_d = sp_q + SPW'(1); end
            OP_STORE: lvar_d[slot] = t_val;
            OP_POP:   sp_d = sp_q - SPW'(1);
            OP_RET: begin
              res_data_d = t_val;
              sp_d       = '0;
              state_d    = S_RESULT;
            end
            OP_DIV: begin
              div_rem_d = '0;
              div_quo_d = n_val[WIDTH-1] ? -n_val : n_val;
              div_den_d = t_val[WIDTH-1] ? -t_val : t_val;
              div_neg_d = n_val[WIDTH-1] ^ t_val[WIDTH-1];
              div_cnt_d = '0;
              state_d   = S_DIVIDE;
            end
            default: begin stack_d[n_idx] = alu_res; sp_d = sp_q - SPW'(1); end
          endcase
        end
      end
      S_DIVIDE: begin
        div_rem_d = rem_nx;
        div_quo_d = quo_nx;
        div_cnt_d = div_cnt_q + CW'(1);
        // last step writes back directly so the quotient lands on the WIDTH-th edge
        if (div_cnt_q == CW'(WIDTH - 1)) begin
          stack_d[n_idx] = div_neg_q ? -quo_nx : quo_nx;
          sp_d           = sp_q - SPW'(1);
          state_d        = S_RUN;
        end
      end
      S_RESULT: if (res_ready) state_d = S_RUN;
      default: ;
    endcase
  end

  // stack contents are pure datapath; sp alone defines validity
  always_ff @(posedge clk) stack_q <= stack_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_RUN;
      sp_q       <= '0;
      res_data_q <= '0;
      err_q      <= 1'b0;
      err_code_q <= '0;
      div_rem_q  <= '0;
      div_quo_q  <= '0;
      div_den_q  <= '0;
      div_neg_q  <= 1'b0;
      div_cnt_q  <= '0;
      for (int i = 0; i < NUM_LVARS; i++) lvar_q[i] <= '0;
    end else begin
      state_q    <= state_d;
      sp_q       <= sp_d;
      res_data_q <= res_data_d;
      err_q      <= err_d;
      err_code_q <= err_code_d;
      div_rem_q  <= div_rem_d;
      div_quo_q  <= div_quo_d;
      div_den_q  <= div_den_d;
      div_neg_q  <= div_neg_d;
      div_cnt_q  <= div_cnt_d;
      lvar_q     <= lvar_d;
    end
  end
endmodule

// File: tb/tb_stack_vm_sequencer.sv
// Testbench for stack_vm_sequencer: directed scenarios followed by random
// instruction streams, compared against a queue-based reference machine.
module tb_stack_vm_sequencer;
  localparam logic [3:0] OP_PUSH = 0, OP_LOAD = 1, OP_STORE = 2, OP_ADD = 3,
                         OP_SUB = 4, OP_MUL = 5, OP_DIV = 6, OP_EQ = 7,
                         OP_NE = 8, OP_GT = 9, OP_GE = 10, OP_POP = 11, OP_RET = 12;

  logic        clk = 0, rst = 1, in_valid = 0, res_ready = 0;
  logic        in_ready, res_valid, err;
  logic [3:0]  in_op = 0;
  logic [31:0] in_arg = 0, res_data;
  logic [4:0]  sp;
  logic [1:0]  err_code;

  int total = 0, bad = 0, rr_delay = 0, ec, n;
  logic [31:0] rv;

  // reference machine
  logic [31:0] stk[$];
  logic [31:0] lv[8];

  stack_vm_sequencer #(.WIDTH(32), .STACK_DEPTH(16), .NUM_LVARS(8)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_op(in_op), .in_arg(in_arg), .res_valid(res_valid), .res_ready(res_ready),
    .res_data(res_data), .sp(sp), .err(err), .err_code(err_code));

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: got no finish want finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  function automatic int m_need(input logic [3:0] op);
    if (op <= OP_LOAD) return 0;
    if (op == OP_STORE || op == OP_POP || op == OP_RET) return 1;
    return 2;
  endfunction

  function automatic void m_reset();
    stk.delete();
    for (int i = 0; i < 8; i++) lv[i] = 0;
  endfunction

  // ec: predicted error code (state untouched when nonzero); r: RET value
  function automatic void m_exec(input logic [3:0] op, input logic [31:0] arg,
                                 output int e, output logic [31:0] r);
    logic [31:0] t, nn;
    longint q;
    e = 0; r = 0;
    t = (stk.size() >= 1) ? stk[$] : 0;
    if (op > OP_RET) e = 3;
    else if (stk.size() < m_need(op)) e = 2;
    else if (op <= OP_LOAD && stk.size() == 16) e = 1;
    else if ((op == OP_LOAD || op == OP_STORE) && arg >= 8) e = 3;
    else if (op == OP_DIV && t == 0) e = 3;
    if (e != 0) return;
    case (op)
      OP_PUSH:  stk.push_back(arg);
      OP_LOAD:  stk.push_back(lv[arg[2:0]]);
      OP_STORE: lv[arg[2:0]] = t;
      OP_POP:   void'(stk.pop_back());
      OP_RET:   begin r = stk.pop_back(); stk.delete(); end
      default: begin
        logic [31:0] res;
        t = stk.pop_back(); nn = stk.pop_back();
        case (op)
          OP_ADD: res = nn + t;
          OP_SUB: res = nn - t;
          OP_MUL: res = nn * t;
          OP_DIV: begin
            q = longint'($signed(nn)) / longint'($signed(t));
            res = q[31:0];
          end
          OP_EQ:  res = (nn == t) ? 1 : 0;
          OP_NE:  res = (nn != t) ? 1 : 0;
          OP_GT:  res = ($signed(nn) >  $signed(t)) ? 1 : 0;
          default: res = ($signed(nn) >= $signed(t)) ? 1 : 0;
        endcase
        stk.push_back(res);
      end
    endcase
  endfunction

  task automatic do_reset();
    @(negedge clk); rst = 1; res_ready = 0; in_valid = 0;
    @(negedge clk); chk("rst_ready_low", 32'(in_ready), 0);
    rst = 0;
    @(negedge clk);
    chk("rst_ready", 32'(in_ready), 1);
    chk("rst_sp", 32'(sp), 0);
    chk("rst_res_valid", 32'(res_valid), 0);
    chk("rst_res_data", res_data, 0);
    chk("rst_err", 32'(err), 0);
    chk("rst_err_code", 32'(err_code), 0);
    m_reset();
  endtask

  // drive one instruction; returns just after the accepting edge
  task automatic issue(input logic [3:0] op, input logic [31:0] arg);
    int w = 0;
    @(negedge clk);
    while (!in_ready && w < 200) begin @(negedge clk); w++; end
    chk("issue_ready", 32'(in_ready), 1);
    in_valid = 1; in_op = op; in_arg = arg;
    @(posedge clk); #1;
    in_valid = 0;
  endtask

  task automatic exec(input logic [3:0] op, input logic [31:0] arg);
    int e, w;
    logic [31:0] r;
    m_exec(op, arg, e, r);
    issue(op, arg);
    if (e != 0) begin
      @(negedge clk);
      chk("err_flag", 32'(err), 1);
      chk("err_code", 32'(err_code), 32'(e));
      chk("err_sp", 32'(sp), 32'(stk.size()));
      @(negedge clk);
      chk("err_stuck", 32'(in_ready), 0);
      do_reset();
    end else if (op == OP_DIV) begin
      w = 0; @(negedge clk);
      while (!in_ready && w < 100) begin w++; @(negedge clk); end
      chk("div_busy_cycles", 32'(w), 32);
      chk("div_sp", 32'(sp), 32'(stk.size()));
    end else if (op == OP_RET) begin
      @(negedge clk);
      chk("ret_valid", 32'(res_valid), 1);
      chk("ret_data", res_data, r);
      chk("ret_sp", 32'(sp), 0);
      repeat (rr_delay) begin
        @(negedge clk);
        chk("ret_hold_valid", 32'(res_valid), 1);
        chk("ret_hold_data", res_data, r);
      end
      res_ready = 1;
      @(posedge clk); #1 res_ready = 0;
      @(negedge clk);
      chk("ret_clear", 32'(res_valid), 0);
    end else begin
      @(negedge clk);
      chk("sp", 32'(sp), 32'(stk.size()));
      chk("no_err", 32'(err), 0);
    end
  endtask

  initial begin
    m_reset();
    do_reset();

    // arithmetic: 3*4-2 = 10, res_valid for exactly one cycle
    exec(OP_PUSH, 3); exec(OP_PUSH, 4); exec(OP_MUL, 0);
    exec(OP_PUSH, 2); exec(OP_SUB, 0); exec(OP_RET, 0);

    // locals: 7+7 = 14, slot persists across RET
    exec(OP_PUSH, 7); exec(OP_STORE, 2); exec(OP_POP, 0);
    exec(OP_LOAD, 2); exec(OP_LOAD, 2); exec(OP_ADD, 0); exec(OP_RET, 0);
    exec(OP_LOAD, 2); exec(OP_RET, 0);

    // -7/2 = -3 with an instruction held valid during DIVIDE
    exec(OP_PUSH, 32'hFFFF_FFF9); exec(OP_PUSH, 2);
    m_exec(OP_DIV, 0, ec, rv);
    issue(OP_DIV, 0);
    in_valid = 1; in_op = OP_PUSH; in_arg = 99;
    n = 0; @(negedge clk);
    while (!in_ready && n < 100) begin n++; @(negedge clk); end
    chk("div_latency", 32'(n), 32);
    chk("div_sp_done", 32'(sp), 32'(stk.size()));
    m_exec(OP_PUSH, 99, ec, rv);
    @(posedge clk); #1 in_valid = 0;
    @(negedge clk); chk("held_push_sp", 32'(sp), 32'(stk.size()));
    exec(OP_POP, 0); exec(OP_RET, 0);

    // most-negative / -1
    exec(OP_PUSH, 32'h8000_0000); exec(OP_PUSH, 32'hFFFF_FFFF);
    exec(OP_DIV, 0); exec(OP_RET, 0);

    // divide by zero, then fill to the top, full-stack legal ops, overflow
    exec(OP_PUSH, 5); exec(OP_PUSH, 0); exec(OP_DIV, 0);
    for (int i = 0; i < 16; i++) exec(OP_PUSH, 32'(i));
    exec(OP_STORE, 1); exec(OP_EQ, 0); exec(OP_PUSH, 1); exec(OP_ADD, 0);
    exec(OP_PUSH, 2); exec(OP_PUSH, 3);
    exec(OP_ADD, 0);                          // underflow on empty stack
    exec(OP_LOAD, 8);                         // bad slot
    exec(OP_RET, 0);                          // RET on empty
    exec(4'd14, 0);                           // bad opcode

    // compares
    exec(OP_PUSH, 5); exec(OP_PUSH, 5); exec(OP_EQ, 0);
    exec(OP_PUSH, 32'hFFFF_FFFF); exec(OP_PUSH, 0); exec(OP_GT, 0); exec(OP_RET, 0);
    exec(OP_PUSH, 3); exec(OP_PUSH, 3); exec(OP_GE, 0); exec(OP_RET, 0);

    // reset mid-divide clears locals too
    exec(OP_PUSH, 7); exec(OP_STORE, 2); exec(OP_PUSH, 100); exec(OP_PUSH, 7);
    issue(OP_DIV, 0);
    repeat (5) @(negedge clk);
    chk("mid_div_busy", 32'(in_ready), 0);
    do_reset();
    exec(OP_LOAD, 2); exec(OP_RET, 0);

    // reset while a result is pending
    exec(OP_PUSH, 9);
    issue(OP_RET, 0);
    repeat (3) @(negedge clk);
    chk("pending_valid", 32'(res_valid), 1);
    do_reset();

    // random streams, mostly legal so the stack gets deep
    for (int i = 0; i < 300; i++) begin
      logic [3:0] op;
      logic [31:0] arg;
      int r;
      r  = $urandom_range(0, 199);
      op = 4'($urandom_range(0, 12));
      if (r == 0) op = 4'($urandom_range(13, 15));
      else if (r > 3) begin
        if (stk.size() < m_need(op)) op = OP_PUSH;
        if ((op == OP_PUSH || op == OP_LOAD) && stk.size() == 16) op = OP_POP;
        if (op == OP_DIV && stk[$] == 0) op = OP_SUB;
      end
      if (op == OP_LOAD || op == OP_STORE)
        arg = (r == 1) ? 32'($urandom_range(8, 40)) : 32'($urandom_range(0, 7));
      else begin
        case ($urandom_range(0, 4))
          0: arg = 32'($urandom_range(0, 20)) - 32'd10;
          1: arg = 32'h8000_0000;
          2: arg = 32'hFFFF_FFFF;
          default: arg = $urandom;
        endcase
      end
      rr_delay = $urandom_range(0, 2);
      exec(op, arg);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/stack_vm_sequencer.md
Name: stack_vm_sequencer

Overview:
- Hardware executor for the stack-machine instruction stream our code generator emits for expression and statement trees (num, lvar, assign, add, sub, mul, div, eq, ne, gt, ge, ret).
- Accepts one instruction per handshake and sequences an operand stack, a local-variable register file and a shared ALU, including a multi-cycle divider.
- Returns the RET value over an output handshake.
- Sits between the instruction source (FIFO or ROM walker) and the result consumer.

Parameters:
- WIDTH, 32, data width of stack entries, locals, immediates and results.
- STACK_DEPTH, 16, number of operand-stack entries (power of 2, >=4).
- NUM_LVARS, 8, number of local-variable slots; slot index = in_arg[$clog2(NUM_LVARS)-1:0].

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- in_valid  in  1  instruction valid.
- in_ready  out  1  sequencer can accept an instruction.
- in_op  in  4  opcode: 0 PUSH, 1 LOAD, 2 STORE, 3 ADD, 4 SUB, 5 MUL, 6 DIV, 7 EQ, 8 NE, 9 GT, 10 GE, 11 POP, 12 RET, 13-15 illegal.
- in_arg  in  WIDTH  immediate (PUSH) or local slot index (LOAD/STORE); ignored otherwise.
- res_valid  out  1  RET value available.
- res_ready  in  1  consumer takes result.
- res_data  out  WIDTH  RET value.
- sp  out  $clog2(STACK_DEPTH)+1  current stack occupancy.
- err  out  1  sticky error flag.
- err_code  out  2  0 none, 1 overflow, 2 underflow, 3 illegal (bad opcode, slot index >= NUM_LVARS, divide by zero).

Behaviour:
- Reset (synchronous, rst high at clk edge): state=RUN, sp=0, all locals=0, in_ready=0 during the rst cycle and 1 from the first cycle after, res_valid=0, res_data=0, err=0, err_code=0. Reset overrides every state, including mid-divide and a pending result.
- States:
  - RUN: in_ready=1.
  - DIVIDE: in_ready=0.
  - RESULT: in_ready=0, res_valid=1.
  - ERROR: in_ready=0, terminal until rst.
- An instruction commits on in_valid && in_ready at a clock edge. Single-cycle ops update stack/locals at that edge; the next instruction may be accepted the following cycle (throughput 1/cycle).
- Semantics (T=top, N=next; binary ops pop N,T and push N op T):
  - PUSH pushes in_arg.
  - LOAD pushes lvar[idx].
  - STORE writes lvar[idx]=T and leaves T on the stack (assignment is an expression).
  - ADD/SUB/MUL: wrap modulo 2^WIDTH; MUL keeps the low WIDTH bits.
  - EQ/NE/GT/GE: signed compare, push 1 or 0.
  - POP discards T.
- DIV: signed, truncates toward zero. Remainder sign follows the dividend (remainder not exported). Iterative restoring algorithm, 1 quotient bit per cycle.
  - Accept edge captures operands and enters DIVIDE.
  - Quotient replaces N,T after exactly WIDTH cycles in DIVIDE; returns to RUN at the same edge.
  - Next instruction can be accepted WIDTH+1 cycles after the DIV accept.
  - Corner case: -2^(WIDTH-1) / -1 yields -2^(WIDTH-1), no error.
- RET:
  - Pops T into res_data and sets sp=0; the next cycle shows res_valid=1.
  - Holds res_data stable until res_valid && res_ready, then returns to RUN with res_valid=0 on the following cycle.
  - Locals persist across RET.
- Errors, detected at the accept edge:
  - Overflow: push when sp==STACK_DEPTH.
  - Underflow: op needs more operands than sp, e.g. ADD with sp<2, RET with sp==0.
  - Illegal: bad opcode, bad slot index, or DIV with T==0 (checked at accept; DIVIDE is not entered).
  - On error: the instruction has no effect, err=1, err_code is latched, state=ERROR. err/err_code hold until rst.
- Boundaries:
  - sp==STACK_DEPTH permits ADD; net push count is what is checked.
  - STORE/EQ at sp==STACK_DEPTH is legal.
  - in_valid while in_ready=0 is ignored; the source must hold the instruction.

Test Plan:
- PUSH 3, PUSH 4, MUL, PUSH 2, SUB, RET, res_ready=1 -> res_data=10, sp=0, res_valid high exactly one cycle.
- PUSH 7, STORE 2, POP, LOAD 2, LOAD 2, ADD, RET -> res_data=14; lvar[2]=7 persists; a second LOAD 2, RET returns 7.
- PUSH -7, PUSH 2, DIV (WIDTH=32) -> in_ready low 32 cycles, stack top=-3, next instruction accepted at cycle 33; PUSH 5, PUSH 0, DIV -> err_code=3, sp unchanged.
- PUSH 17 times with STACK_DEPTH=16 -> 17th rejected, err_code=1, sp=16, in_ready=0 until rst; ADD on empty stack after reset -> err_code=2.
- PUSH 5, PUSH 5, EQ; PUSH -1, PUSH 0, GT; RET -> 0 (-1>0 is false); separately PUSH 3, PUSH 3, GE, RET -> 1.
- Assert rst mid-DIVIDE and during RESULT with res_ready=0 -> next cycle state RUN, sp=0, res_valid=0, locals=0, err=0.
